// File: rtl/imem_uart_loader.sv
// rtl/imem_uart_loader.sv - boot loader that fills instruction memory from a framed UART byte stream
module imem_uart_loader #(
    parameter int          ADDR_W      = 12,
    parameter int          MAX_WORDS   = 128,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int          TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              error
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN0  = 3'd1,
        S_LEN1  = 3'd2,
        S_DATA  = 3'd3,
        S_CSUM  = 3'd4,
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [7:0]      len_lo;
    logic [15:0]     len;
    logic [15:0]     word_cnt;
    logic [1:0]      byte_idx;
    logic [23:0]     asm_word;
    logic [7:0]      csum;
    logic [TO_W-1:0] idle_cnt;

    logic [15:0]     len_full;
    logic            len_bad;
    logic            last_word;
    logic            in_frame;
    logic            timeout_hit;

    assign len_full    = {rx_data, len_lo};
    assign len_bad     = (len_full == 16'd0) || (len_full > 16'(MAX_WORDS));
    assign last_word   = (word_cnt == len - 16'd1);
    assign in_frame    = (state == S_LEN0) || (state == S_LEN1) ||
                         (state == S_DATA) || (state == S_CSUM);
    // The expiry cycle is the TIMEOUT_CYC-th cycle after the last byte; a byte in it still wins.
    assign timeout_hit = (idle_cnt == TO_W'(TIMEOUT_CYC - 1));

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Frame parsing: next state from the incoming byte, with idle timeout as fallback
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (rx_valid && rx_data == SYNC_BYTE) state_nx = S_LEN0;
            end
            S_LEN0: begin
                if (rx_valid) state_nx = S_LEN1;
            end
            S_LEN1: begin
                if (rx_valid) state_nx = len_bad ? S_ERROR : S_DATA;
            end
            S_DATA: begin
                if (rx_valid && byte_idx == 2'd3 && last_word) state_nx = S_CSUM;
            end
            S_CSUM: begin
                if (rx_valid) state_nx = (rx_data == csum) ? S_DONE : S_ERROR;
            end
            S_DONE: begin
                state_nx = S_DONE;
            end
            S_ERROR: begin
                if (rx_valid && rx_data == SYNC_BYTE) state_nx = S_LEN0;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
        if (in_frame && !rx_valid && timeout_hit) state_nx = S_ERROR;
    end

    // Status outputs decoded from the state register, so they move one clock after the deciding byte
    always_comb begin
        done      = (state == S_DONE);
        error     = (state == S_ERROR);
        core_hold = (state != S_DONE);
    end

    // Datapath: length capture, word assembly, checksum, idle counter and the write strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            len_lo    <= '0;
            len       <= '0;
            word_cnt  <= '0;
            byte_idx  <= '0;
            asm_word  <= '0;
            csum      <= '0;
            idle_cnt  <= '0;
        end else begin
            mem_we <= 1'b0;
            if (in_frame && !rx_valid) begin
                idle_cnt <= idle_cnt + TO_W'(1);
            end else begin
                idle_cnt <= '0;
            end
            if (rx_valid) begin
                case (state)
                    S_LEN0: begin
                        len_lo <= rx_data;
                    end
                    S_LEN1: begin
                        len      <= len_full;
                        word_cnt <= '0;
                        byte_idx <= '0;
                        csum     <= '0;
                    end
                    S_DATA: begin
                        csum     <= csum ^ rx_data;
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: asm_word[7:0]   <= rx_data;
                            2'd1: asm_word[15:8]  <= rx_data;
                            2'd2: asm_word[23:16] <= rx_data;
                            default: begin
                                mem_we    <= 1'b1;
                                mem_addr  <= {word_cnt[ADDR_W-3:0], 2'b00};
                                mem_wdata <= {rx_data, asm_word};
                                word_cnt  <= word_cnt + 16'd1;
                            end
                        endcase
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_uart_loader.sv
// tb/tb_imem_uart_loader.sv - self-checking bench for imem_uart_loader
module tb_imem_uart_loader;

    localparam int TO = 50;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        core_hold;
    logic        done;
    logic        error;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    imem_uart_loader #(
        .ADDR_W(12),
        .MAX_WORDS(128),
        .SYNC_BYTE(8'hA5),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .core_hold(core_hold),
        .done(done),
        .error(error)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: keeps the bytes since the sync marker and judges them as a whole
    bit          m_in_frame, m_done, m_err, exp_we;
    logic [7:0]  m_frame[$];
    int          m_len, m_idle, m_n;
    logic [7:0]  m_x;
    logic [11:0] exp_addr;
    logic [31:0] exp_data;

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_in_frame = 0; m_done = 0; m_err = 0; m_idle = 0; exp_we = 0;
            m_frame.delete();
        end else begin
            exp_we = 0;
            if (m_done) begin
            end else if (!m_in_frame) begin
                if (rx_valid && rx_data == 8'hA5) begin
                    m_in_frame = 1; m_err = 0; m_idle = 0;
                    m_frame.delete();
                end
            end else if (rx_valid) begin
                m_idle = 0;
                m_frame.push_back(rx_data);
                m_n = m_frame.size();
                if (m_n == 2) begin
                    m_len = int'({m_frame[1], m_frame[0]});
                    if (m_len == 0 || m_len > 128) begin
                        m_in_frame = 0; m_err = 1;
                    end
                end else if (m_n <= 2 + 4 * m_len && (m_n - 2) % 4 == 0) begin
                    exp_we   = 1;
                    exp_addr = 12'(((m_n - 2) / 4 - 1) * 4);
                    exp_data = {m_frame[m_n-1], m_frame[m_n-2], m_frame[m_n-3], m_frame[m_n-4]};
                end else if (m_n == 3 + 4 * m_len) begin
                    m_x = 8'h00;
                    for (int i = 2; i < m_n - 1; i++) m_x = m_x ^ m_frame[i];
                    if (m_x == rx_data) m_done = 1;
                    else m_err = 1;
                    m_in_frame = 0;
                end
            end else begin
                m_idle++;
                if (m_idle == TO) begin
                    m_in_frame = 0; m_err = 1;
                end
            end
        end
    end

    // Per-cycle compare against the model, plus a log of every write the DUT makes
    logic [11:0] wr_addr[$];
    logic [31:0] wr_data[$];

    initial forever begin
        @(negedge clk);
        if (reset_n) begin
            chk("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
            if (exp_we) begin
                chk("mem_addr", {20'd0, mem_addr}, {20'd0, exp_addr});
                chk("mem_wdata", mem_wdata, exp_data);
            end
            chk("done", {31'd0, done}, {31'd0, m_done});
            chk("error", {31'd0, error}, {31'd0, m_err});
            chk("core_hold", {31'd0, core_hold}, {31'd0, !m_done});
            if (mem_we) begin
                wr_addr.push_back(mem_addr);
                wr_data.push_back(mem_wdata);
            end
        end
    end

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        reset_n  = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        idle(1);
    endtask

    logic [7:0] good_f [12] = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                                8'hB7, 8'h05, 8'h00, 8'h20, 8'h81};
    logic [7:0] one_f  [8]  = '{8'hA5, 8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h44};
    int         base;
    logic [7:0] big_x;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rx_valid = 1'b0;
        reset_n  = 1'b0;
        idle(2);
        chk("reset core_hold", {31'd0, core_hold}, 32'd1);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset error", {31'd0, error}, 32'd0);
        chk("reset mem_we", {31'd0, mem_we}, 32'd0);
        reset_n = 1'b1;
        idle(2);

        // Good 2-word frame preceded by noise bytes
        base = wr_addr.size();
        send(8'h55); send(8'hFF); idle(1);
        for (int i = 0; i < 11; i++) send(good_f[i]);
        chk("good done before csum", {31'd0, done}, 32'd0);
        send(good_f[11]);
        chk("good done", {31'd0, done}, 32'd1);
        chk("good core_hold", {31'd0, core_hold}, 32'd0);
        chk("good write count", wr_addr.size() - base, 32'd2);
        if (wr_addr.size() - base == 2) begin
            chk("good addr0", {20'd0, wr_addr[base]}, 32'h000);
            chk("good data0", wr_data[base], 32'h00000013);
            chk("good addr1", {20'd0, wr_addr[base+1]}, 32'h004);
            chk("good data1", wr_data[base+1], 32'h200005B7);
        end
        send(8'hA5); idle(2);
        chk("done sticky", {31'd0, done}, 32'd1);

        // Bad checksum, then recovery with a valid 1-word frame
        do_reset();
        base = wr_addr.size();
        for (int i = 0; i < 11; i++) send(good_f[i]);
        send(8'h80);
        chk("badcs error", {31'd0, error}, 32'd1);
        chk("badcs done", {31'd0, done}, 32'd0);
        chk("badcs core_hold", {31'd0, core_hold}, 32'd1);
        chk("badcs writes", wr_addr.size() - base, 32'd2);
        idle(3);
        base = wr_addr.size();
        send(one_f[0]);
        chk("recover error cleared", {31'd0, error}, 32'd0);
        for (int i = 1; i < 8; i++) send(one_f[i]);
        chk("recover done", {31'd0, done}, 32'd1);
        chk("recover write count", wr_addr.size() - base, 32'd1);
        if (wr_addr.size() - base == 1)
            chk("recover data", wr_data[base], 32'h11223344);

        // Bad lengths: zero and 129
        do_reset();
        base = wr_addr.size();
        send(8'hA5); send(8'h00); send(8'h00);
        chk("len0 error", {31'd0, error}, 32'd1);
        idle(2);
        send(8'hA5); send(8'h81); send(8'h00);
        chk("len129 error", {31'd0, error}, 32'd1);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04); idle(2);
        chk("badlen writes", wr_addr.size() - base, 32'd0);

        // Timeout after two data bytes
        do_reset();
        base = wr_addr.size();
        send(8'hA5); send(8'h01); send(8'h00); send(8'h13); send(8'h00);
        idle(TO - 1);
        chk("timeout not yet", {31'd0, error}, 32'd0);
        idle(1);
        chk("timeout error", {31'd0, error}, 32'd1);
        chk("timeout writes", wr_addr.size() - base, 32'd0);

        // Byte landing in the expiry cycle keeps the frame alive
        do_reset();
        send(8'hA5); send(8'h01); send(8'h00); send(8'h13); send(8'h00);
        idle(TO - 1);
        send(8'h00);
        chk("expiry byte no error", {31'd0, error}, 32'd0);
        send(8'h00); send(8'h13);
        chk("expiry frame done", {31'd0, done}, 32'd1);

        // Reset between data bytes 6 and 7, then a full reload
        do_reset();
        for (int i = 0; i < 9; i++) send(good_f[i]);
        reset_n = 1'b0;
        #1;
        chk("midreset core_hold", {31'd0, core_hold}, 32'd1);
        chk("midreset mem_we", {31'd0, mem_we}, 32'd0);
        chk("midreset done", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        idle(1);
        base = wr_addr.size();
        for (int i = 0; i < 12; i++) send(good_f[i]);
        chk("reload done", {31'd0, done}, 32'd1);
        chk("reload writes", wr_addr.size() - base, 32'd2);
        if (wr_addr.size() - base == 2)
            chk("reload first addr", {20'd0, wr_addr[base]}, 32'h000);

        // Maximum-size 128-word frame
        do_reset();
        base = wr_addr.size();
        big_x = 8'h00;
        send(8'hA5); send(8'h80); send(8'h00);
        for (int i = 0; i < 512; i++) begin
            send(8'(i * 7 + 3));
            big_x = big_x ^ 8'(i * 7 + 3);
        end
        send(big_x);
        chk("big write count", wr_addr.size() - base, 32'd128);
        if (wr_addr.size() > 0)
            chk("big last addr", {20'd0, wr_addr[wr_addr.size()-1]}, 32'h1FC);
        chk("big done", {31'd0, done}, 32'd1);

        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
